// File: rtl/pipeline_uart_transmitter.sv
// 8-N-1 / 8-N-2 UART transmitter with a one-entry holding register and an internal baud divider.
// The serial line, busy and done outputs are all registered and aligned to the same frame timing.
module pipeline_uart_transmitter #(
  parameter int unsigned BAUD_DIV  = 5208,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TX_EN,
  input  logic [7:0] TX_DATA,
  output logic       TX_STATUS,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       UART_TX
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                status_q, status_d;

  logic bit_end;
  logic accept;
  logic load;

  assign bit_end = (baud_q == BAUD_LAST);
  assign accept  = TX_EN & status_q;

  // Next-state, counters, holding register and registered outputs
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    done_d       = 1'b0;
    load         = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_valid_q) begin
          load = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            // A held byte starts on the very edge the frame ends, no idle gap
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      state_d      = ST_START;
      shift_d      = hold_data_q;
      baud_d       = '0;
      bit_d        = '0;
      hold_valid_d = 1'b0;
    end

    // Accept only while empty, so it never collides with a reload
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = TX_DATA;
    end

    case (state_q)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    busy_d   = (state_q != ST_IDLE);
    status_d = ~hold_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      status_q     <= status_d;
    end
  end

  assign UART_TX   = tx_q;
  assign TX_BUSY   = busy_q;
  assign TX_DONE   = done_q;
  assign TX_STATUS = status_q;

endmodule

// File: tb/tb_pipeline_uart_transmitter.sv
// Bench for pipeline_uart_transmitter: frame scoreboard on a BAUD_DIV=4/1-stop instance,
// directed waveform check on a BAUD_DIV=3/2-stop instance.
module tb_pipeline_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a_n, en_a, status_a, busy_a, done_a, tx_a;
  logic [7:0] data_a;
  logic       rst_b_n, en_b, status_b, busy_b, done_b, tx_b;
  logic [7:0] data_b;

  pipeline_uart_transmitter #(.BAUD_DIV(4), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .reset(rst_a_n), .TX_EN(en_a), .TX_DATA(data_a),
    .TX_STATUS(status_a), .TX_BUSY(busy_a), .TX_DONE(done_a), .UART_TX(tx_a)
  );

  pipeline_uart_transmitter #(.BAUD_DIV(3), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .reset(rst_b_n), .TX_EN(en_b), .TX_DATA(data_b),
    .TX_STATUS(status_b), .TX_BUSY(busy_b), .TX_DONE(done_b), .UART_TX(tx_b)
  );

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    int          start;
    logic [39:0] samp;
  } frame_t;

  frame_t     rx_q[$];
  logic [7:0] exp_q[$];
  int         done_a_q[$];
  int         busy_a_cnt = 0;

  // Line monitor for instance A: captures 40 samples from each falling start edge
  initial begin : mon_a
    logic   mon_act;
    int     mon_k;
    frame_t mon_f;
    mon_act = 1'b0;
    mon_k   = 0;
    mon_f.start = 0;
    mon_f.samp  = '0;
    forever begin
      @(negedge clk);
      if (!rst_a_n) begin
        mon_act = 1'b0;
      end else begin
        if (done_a) done_a_q.push_back(cyc);
        if (busy_a) busy_a_cnt++;
        if (mon_act) begin
          mon_f.samp[mon_k] = tx_a;
          mon_k++;
          if (mon_k == 40) begin
            rx_q.push_back(mon_f);
            mon_act = 1'b0;
          end
        end else if (!tx_a) begin
          mon_act     = 1'b1;
          mon_f.start = cyc;
          mon_f.samp  = '0;
          mon_k       = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] exp_frame_a(input logic [7:0] b);
    logic [39:0] v;
    int j;
    for (int k = 0; k < 40; k++) begin
      j = k / 4;
      if (j == 0)      v[k] = 1'b0;
      else if (j <= 8) v[k] = b[j-1];
      else             v[k] = 1'b1;
    end
    return v;
  endfunction

  // Drives one accept cycle on A; acc is the cycle count right after the accepting edge
  task automatic send_a(input logic [7:0] b, output int acc);
    en_a   = 1'b1;
    data_a = b;
    @(posedge clk);
    #1;
    acc    = cyc;
    en_a   = 1'b0;
    data_a = ~b;
  endtask

  task automatic get_frame(input string tag, output int start);
    frame_t     f;
    logic [7:0] b;
    for (int w = 0; w < 200 && rx_q.size() == 0; w++) @(negedge clk);
    chk({tag, "_present"}, 64'(rx_q.size() != 0), 64'(1));
    start = -1000;
    if (rx_q.size() != 0) begin
      f     = rx_q.pop_front();
      start = f.start;
      b     = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      chk(tag, 64'(f.samp), 64'(exp_frame_a(b)));
    end
  endtask

  function automatic int done_at(input int idx);
    return (done_a_q.size() > idx) ? done_a_q[idx] : -1;
  endfunction

  initial begin : main
    int acc, acc2, acc3, f1, f2, d0, b0, lows, fb;
    logic [32:0] obs_w, exp_w, obs_d, exp_d;

    en_a = 1'b0; data_a = 8'h00; rst_a_n = 1'b0;
    en_b = 1'b0; data_b = 8'h00; rst_b_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset_tx",     64'(tx_a),     64'(1));
    chk("reset_status", 64'(status_a), 64'(1));
    chk("reset_busy",   64'(busy_a),   64'(0));
    chk("reset_done",   64'(done_a),   64'(0));
    chk("reset_tx_b",   64'(tx_b),     64'(1));
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of data bit 3 of 0x00
    send_a(8'h00, acc);
    while (cyc < acc + 19) @(negedge clk);
    @(posedge clk);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("midrst_tx",     64'(tx_a),     64'(1));
    chk("midrst_status", 64'(status_a), 64'(1));
    chk("midrst_busy",   64'(busy_a),   64'(0));
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    lows = 0;
    b0   = busy_a_cnt;
    repeat (20) begin
      @(negedge clk);
      if (!tx_a) lows++;
    end
    chk("midrst_idle_lows", 64'(lows), 64'(0));
    chk("midrst_no_frame",  64'(rx_q.size()), 64'(0));
    chk("midrst_no_busy",   64'(busy_a_cnt - b0), 64'(0));

    // Single byte
    d0 = done_a_q.size();
    b0 = busy_a_cnt;
    @(negedge clk);
    send_a(8'h55, acc);
    exp_q.push_back(8'h55);
    get_frame("single", f1);
    chk("single_latency", 64'(f1), 64'(acc + 2));
    repeat (5) @(negedge clk);
    chk("single_done_cnt", 64'(done_a_q.size() - d0), 64'(1));
    chk("single_done_cyc", 64'(done_at(d0)), 64'(f1 + 39));
    chk("single_busy_len", 64'(busy_a_cnt - b0), 64'(40));

    // Queued byte plus back-pressure
    d0 = done_a_q.size();
    @(negedge clk);
    send_a(8'hA3, acc);
    exp_q.push_back(8'hA3);
    for (int i = 0; i < 10 && !status_a; i++) @(negedge clk);
    chk("queue_status_rise", 64'(status_a), 64'(1));
    send_a(8'h0F, acc2);
    exp_q.push_back(8'h0F);
    repeat (3) @(negedge clk);
    chk("bp_status_low", 64'(status_a), 64'(0));
    send_a(8'hFF, acc3);
    get_frame("queued_1", f1);
    get_frame("queued_2", f2);
    chk("queued_gap", 64'(f2), 64'(f1 + 40));
    repeat (85) @(negedge clk);
    chk("bp_no_third",    64'(rx_q.size()), 64'(0));
    chk("queued_done_cnt", 64'(done_a_q.size() - d0), 64'(2));
    chk("queued_done1",    64'(done_at(d0)),     64'(f1 + 39));
    chk("queued_done2",    64'(done_at(d0 + 1)), 64'(f2 + 39));

    // Accept on the edge that ends the stop bit
    d0 = done_a_q.size();
    @(negedge clk);
    send_a(8'h3C, acc);
    exp_q.push_back(8'h3C);
    while (cyc < acc + 40) @(negedge clk);
    send_a(8'hC5, acc2);
    exp_q.push_back(8'hC5);
    get_frame("stopend_1", f1);
    get_frame("stopend_2", f2);
    chk("stopend_lat1",  64'(f1), 64'(acc + 2));
    chk("stopend_start", 64'(f2), 64'(acc2 + 2));
    repeat (5) @(negedge clk);
    chk("stopend_done_cnt", 64'(done_a_q.size() - d0), 64'(2));
    chk("stopend_done1",    64'(done_at(d0)),     64'(f1 + 39));
    chk("stopend_done2",    64'(done_at(d0 + 1)), 64'(f2 + 39));

    // Two stop bits, BAUD_DIV=3, byte 0x80
    for (int k = 0; k < 33; k++) begin
      if (k / 3 == 0)      exp_w[k] = 1'b0;
      else if (k / 3 <= 8) exp_w[k] = (k / 3 == 8);
      else                 exp_w[k] = 1'b1;
    end
    exp_d     = '0;
    exp_d[32] = 1'b1;
    @(negedge clk);
    en_b   = 1'b1;
    data_b = 8'h80;
    @(posedge clk);
    #1;
    acc    = cyc;
    en_b   = 1'b0;
    data_b = 8'h7F;
    for (int i = 0; i < 10 && tx_b; i++) @(negedge clk);
    fb = cyc;
    chk("two_stop_latency", 64'(fb), 64'(acc + 2));
    obs_w[0] = tx_b;
    obs_d[0] = done_b;
    for (int k = 1; k < 33; k++) begin
      @(negedge clk);
      obs_w[k] = tx_b;
      obs_d[k] = done_b;
    end
    chk("two_stop_wave", 64'(obs_w), 64'(exp_w));
    chk("two_stop_done", 64'(obs_d), 64'(exp_d));
    @(negedge clk);
    chk("two_stop_idle_tx",   64'(tx_b),   64'(1));
    chk("two_stop_idle_busy", 64'(busy_b), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
